// File: rtl/teclado_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, key-code width
// and the 4x4 legend map used by consumers of the key index.
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } state_e;

  function automatic int key_width(input int n_rows, input int n_cols);
    int n;
    n = n_rows * n_cols;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Legend 1,2,3,A / 4,5,6,B / 7,8,9,C / *,0,#,D with * -> E and # -> F.
  function automatic logic [3:0] idx_to_hex(input logic [3:0] idx);
    logic [3:0] hex;
    case (idx)
      4'd0:    hex = 4'h1;
      4'd1:    hex = 4'h2;
      4'd2:    hex = 4'h3;
      4'd3:    hex = 4'hA;
      4'd4:    hex = 4'h4;
      4'd5:    hex = 4'h5;
      4'd6:    hex = 4'h6;
      4'd7:    hex = 4'hB;
      4'd8:    hex = 4'h7;
      4'd9:    hex = 4'h8;
      4'd10:   hex = 4'h9;
      4'd11:   hex = 4'hC;
      4'd12:   hex = 4'hE;
      4'd13:   hex = 4'h0;
      4'd14:   hex = 4'hF;
      default: hex = 4'hD;
    endcase
    return hex;
  endfunction

endpackage

// File: rtl/module_key_fifo.sv
// First-word fall-through key-code FIFO with occupancy count. A push into a
// full FIFO succeeds only when a pop retires the head in the same cycle.
module module_key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    empty    = (count_q == '0);
    full     = (count_q == (PW+1)'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rdata = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/module_teclado_scan_fifo.sv
// Keypad scanner: one-hot column scan, 2-FF row synchroniser, debounced
// press/release FSM and a FIFO of confirmed key indices drained by valid/ready.
module module_teclado_scan_fifo
  import teclado_pkg::*;
#(
  parameter int N_ROWS          = 4,
  parameter int N_COLS          = 4,
  parameter int SCAN_TICKS      = 1000,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int FIFO_DEPTH      = 4,
  parameter int KEY_W           = key_width(N_ROWS, N_COLS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_ROWS-1:0]             row,
  output logic [N_COLS-1:0]             col,
  output logic [KEY_W-1:0]              code,
  output logic                          valido,
  input  logic                          ready,
  output logic                          key_held,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int CW = $clog2(N_COLS);
  localparam int RW = $clog2(N_ROWS);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  state_e              state_q, state_d;
  logic [N_ROWS-1:0]   row_meta_q, row_meta_d;
  logic [N_ROWS-1:0]   s_row_q, s_row_d;
  logic [CW-1:0]       col_idx_q, col_idx_d;
  logic [TW-1:0]       dwell_q, dwell_d;
  logic [DW-1:0]       deb_q, deb_d;
  logic [N_ROWS-1:0]   cand_row_q, cand_row_d;
  logic [RW-1:0]       cand_idx_q, cand_idx_d;
  logic                overflow_q, overflow_d;

  logic [RW-1:0]       s_row_idx;
  logic                s_row_onehot;
  logic [CW-1:0]       next_col_idx;
  logic [DW-1:0]       deb_inc;
  logic                deb_done;
  logic                push, fifo_full, fifo_empty;
  logic [KEY_W-1:0]    push_code;

  always_comb begin
    row_meta_d   = row;
    s_row_d      = row_meta_q;
    s_row_onehot = (s_row_q != '0) && ((s_row_q & (s_row_q - 1'b1)) == '0);
    s_row_idx    = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      if (s_row_q[i]) s_row_idx = RW'(i);
    end
    next_col_idx = (col_idx_q == CW'(N_COLS - 1)) ? '0 : col_idx_q + 1'b1;
    // Saturating increment: the counter can never wrap while parked in a state.
    deb_inc      = (deb_q == DW'(DEBOUNCE_CYCLES)) ? deb_q : deb_q + 1'b1;
    deb_done     = (deb_inc == DW'(DEBOUNCE_CYCLES));
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    dwell_d    = dwell_q;
    deb_d      = deb_q;
    cand_row_d = cand_row_q;
    cand_idx_d = cand_idx_q;
    push       = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == TW'(SCAN_TICKS - 1)) begin
          dwell_d = '0;
          if (s_row_onehot) begin
            state_d    = CONFIRM;
            cand_row_d = s_row_q;
            cand_idx_d = s_row_idx;
            deb_d      = '0;
          end else begin
            // Idle or ghosted (multi-row) samples both just move the scan on.
            col_idx_d = next_col_idx;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      CONFIRM: begin
        if (s_row_q != cand_row_q) begin
          state_d   = SCAN;
          col_idx_d = next_col_idx;
          dwell_d   = '0;
          deb_d     = '0;
        end else if (deb_done) begin
          push    = 1'b1;
          state_d = HELD;
          deb_d   = '0;
        end else begin
          deb_d = deb_inc;
        end
      end
      HELD: begin
        if (s_row_q != '0) begin
          deb_d = '0;
        end else if (deb_done) begin
          state_d   = SCAN;
          col_idx_d = next_col_idx;
          dwell_d   = '0;
          deb_d     = '0;
        end else begin
          deb_d = deb_inc;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    col            = '0;
    col[col_idx_q] = 1'b1;
    key_held       = (state_q == HELD);
    push_code      = KEY_W'(int'(cand_idx_q) * N_COLS + int'(col_idx_q));
    overflow_d     = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    // A drop sets the flag even when clr_ovf is asserted in the same cycle.
    if (push && fifo_full && !(valido && ready)) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      row_meta_q <= '0;
      s_row_q    <= '0;
      col_idx_q  <= '0;
      dwell_q    <= '0;
      deb_q      <= '0;
      cand_row_q <= '0;
      cand_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_meta_q <= row_meta_d;
      s_row_q    <= s_row_d;
      col_idx_q  <= col_idx_d;
      dwell_q    <= dwell_d;
      deb_q      <= deb_d;
      cand_row_q <= cand_row_d;
      cand_idx_q <= cand_idx_d;
      overflow_q <= overflow_d;
    end
  end

  module_key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_code),
    .pop   (ready),
    .rdata (code),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

  assign valido   = !fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_module_teclado_scan_fifo.sv
// Bench for the keypad scanner: a keypad model drives rows from the column
// drive; pops are logged and compared with codes predicted from the key grid.
module tb_module_teclado_scan_fifo;
  import teclado_pkg::*;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic [KW-1:0] code;
  logic          valido;
  logic          ready;
  logic          key_held;
  logic [2:0]    count;
  logic          overflow;
  logic          clr_ovf;

  logic [NR*NC-1:0] pressed;
  bit               rand_ready = 1'b0;
  int               checks = 0;
  int               failures = 0;
  int               popped[$];

  always #5 clk = ~clk;

  module_teclado_scan_fifo #(
    .N_ROWS          (NR),
    .N_COLS          (NC),
    .SCAN_TICKS      (4),
    .DEBOUNCE_CYCLES (8),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .code     (code),
    .valido   (valido),
    .ready    (ready),
    .key_held (key_held),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // Keypad: a pressed key connects its column drive to its row line.
  always_comb begin
    row = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r*NC+c] && col[c]) row[r] = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && valido && ready) popped.push_back(int'(code));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_col(input int c, input logic want, input string what);
    int n = 0;
    while (col[c] !== want && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (col[c] !== want) begin
      failures++;
      $display("FAIL %s timeout col=%b want col[%0d]=%b", what, col, c, want);
    end
  endtask

  task automatic wait_held(input logic want, input string what);
    int n = 0;
    while (key_held !== want && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (key_held !== want) begin
      failures++;
      $display("FAIL %s timeout key_held=%b want=%b", what, key_held, want);
    end
  endtask

  task automatic press_key(input int r, input int c, input int hold);
    wait_col(c, 1'b0, "press_pre");
    pressed[r*NC+c] = 1'b1;
    wait_held(1'b1, "press_confirm");
    tick(hold);
    pressed[r*NC+c] = 1'b0;
    wait_held(1'b0, "press_release");
  endtask

  task automatic test_reset();
    logic [NC-1:0] exp_col;
    rst = 1'b1; ready = 1'b0; clr_ovf = 1'b0; pressed = '0;
    tick(3);
    rst = 1'b0;
    checks++; if (col !== 4'b0001) begin failures++; $display("FAIL reset_col got=%b exp=0001", col); end
    checks++; if (valido !== 1'b0) begin failures++; $display("FAIL reset_valido got=%b exp=0", valido); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_key_held got=%b exp=0", key_held); end
    checks++; if (code !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", code); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_col = 4'b0001 << ((k / 4) % 4);
      checks++;
      if (col !== exp_col) begin
        failures++;
        $display("FAIL scan_seq cycle=%0d got=%b exp=%b", k, col, exp_col);
      end
    end
  endtask

  task automatic test_hex_map();
    string      legend = "123A456B789C*0#D";
    byte        ch;
    logic [3:0] exp_hex;
    for (int i = 0; i < 16; i++) begin
      ch = legend[i];
      if (ch == "*")       exp_hex = 4'hE;
      else if (ch == "#")  exp_hex = 4'hF;
      else if (ch >= "A")  exp_hex = 4'(int'(ch) - 55);
      else                 exp_hex = 4'(int'(ch) - 48);
      checks++;
      if (idx_to_hex(4'(i)) !== exp_hex) begin
        failures++;
        $display("FAIL hex_map idx=%0d got=%h exp=%h", i, idx_to_hex(4'(i)), exp_hex);
      end
    end
  endtask

  task automatic test_hold();
    ready = 1'b1; popped.delete();
    wait_col(2, 1'b0, "hold_pre");
    pressed[1*NC+2] = 1'b1;
    tick(40);
    checks++; if (popped.size() != 1) begin failures++; $display("FAIL hold_pushes got=%0d exp=1", popped.size()); end
    if (popped.size() >= 1) begin
      checks++; if (popped[0] != 6) begin failures++; $display("FAIL hold_code got=%0d exp=6", popped[0]); end
    end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL hold_key_held got=%b exp=1", key_held); end
    pressed = '0;
    tick(9);
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL release_early got=%b exp=1", key_held); end
    tick();
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL release_fall got=%b exp=0", key_held); end
    checks++; if (col !== 4'b1000) begin failures++; $display("FAIL release_next_col got=%b exp=1000", col); end
  endtask

  task automatic test_latency();
    ready = 1'b0; popped.delete();
    wait_col(1, 1'b0, "lat_pre");
    pressed[2*NC+1] = 1'b1;
    wait_col(1, 1'b1, "lat_col");
    tick(11);
    checks++; if (valido !== 1'b0) begin failures++; $display("FAIL lat_early_valido got=%b exp=0", valido); end
    checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL lat_early_held got=%b exp=0", key_held); end
    tick();
    checks++; if (valido !== 1'b1) begin failures++; $display("FAIL lat_valido got=%b exp=1", valido); end
    checks++; if (code !== 4'd9) begin failures++; $display("FAIL lat_code got=%0d exp=9", code); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL lat_count got=%0d exp=1", count); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL lat_held got=%b exp=1", key_held); end
    tick(3);
    checks++; if (valido !== 1'b1 || code !== 4'd9) begin failures++; $display("FAIL stall_stable got=%b/%0d exp=1/9", valido, code); end
    pressed = '0;
    wait_held(1'b0, "lat_release");
    ready = 1'b1; tick(2); ready = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL lat_drain got=%0d exp=0", count); end
    checks++; if (popped.size() != 1 || popped[0] != 9) begin failures++; $display("FAIL lat_popped got_n=%0d exp=1 item 9", popped.size()); end
  endtask

  task automatic test_bounce();
    bit held_seen = 1'b0;
    ready = 1'b1; popped.delete();
    for (int i = 0; i < 10; i++) begin
      pressed[3*NC+0] = (i % 2 == 0);
      for (int j = 0; j < 3; j++) begin
        tick();
        if (key_held) held_seen = 1'b1;
      end
    end
    checks++; if (popped.size() != 0) begin failures++; $display("FAIL bounce_no_push got=%0d exp=0", popped.size()); end
    checks++; if (held_seen) begin failures++; $display("FAIL bounce_held got=1 exp=0"); end
    pressed[3*NC+0] = 1'b1;
    tick(50);
    checks++; if (popped.size() != 1) begin failures++; $display("FAIL bounce_pushes got=%0d exp=1", popped.size()); end
    if (popped.size() >= 1) begin
      checks++; if (popped[0] != 12) begin failures++; $display("FAIL bounce_code got=%0d exp=12", popped[0]); end
    end
    pressed = '0;
    wait_held(1'b0, "bounce_release");
  endtask

  task automatic test_ghost();
    logic [NC-1:0] prev;
    int            changes = 0;
    bit            held_seen = 1'b0;
    ready = 1'b1; popped.delete();
    pressed[0*NC+0] = 1'b1;
    pressed[2*NC+0] = 1'b1;
    prev = col;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (col !== prev) changes++;
      prev = col;
      if (key_held) held_seen = 1'b1;
    end
    checks++; if (changes != 10) begin failures++; $display("FAIL ghost_scan changes=%0d exp=10", changes); end
    checks++; if (popped.size() != 0) begin failures++; $display("FAIL ghost_push got=%0d exp=0", popped.size()); end
    checks++; if (held_seen) begin failures++; $display("FAIL ghost_held got=1 exp=0"); end
    pressed = '0;
    tick(4);
  endtask

  task automatic test_overflow();
    int keys[5] = '{1, 7, 10, 13, 3};
    ready = 1'b0; popped.delete();
    foreach (keys[i]) press_key(keys[i] / NC, keys[i] % NC, 2);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (code !== 4'd1) begin failures++; $display("FAIL ovf_head got=%0d exp=1", code); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    ready = 1'b1; tick(4); ready = 1'b0; tick();
    checks++; if (popped.size() != 4) begin failures++; $display("FAIL ovf_drain_n got=%0d exp=4", popped.size()); end
    for (int i = 0; i < 4 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] != keys[i]) begin failures++; $display("FAIL ovf_order idx=%0d got=%0d exp=%0d", i, popped[i], keys[i]); end
    end
    checks++; if (count !== 3'd0 || valido !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0d/%b exp=0/0", count, valido); end
  endtask

  task automatic test_full_pop_push();
    int fill[4]  = '{4, 5, 11, 14};
    int order[5] = '{4, 5, 11, 14, 15};
    ready = 1'b0; popped.delete();
    foreach (fill[i]) press_key(fill[i] / NC, fill[i] % NC, 1);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_fill got=%0d exp=4", count); end
    wait_col(3, 1'b0, "full_pre");
    pressed[3*NC+3] = 1'b1;
    wait_col(3, 1'b1, "full_col");
    tick(11);
    ready = 1'b1; tick(); ready = 1'b0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_popush_count got=%0d exp=4", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_popush_ovf got=%b exp=0", overflow); end
    checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL full_popush_held got=%b exp=1", key_held); end
    checks++; if (code !== 4'd5) begin failures++; $display("FAIL full_popush_head got=%0d exp=5", code); end
    pressed = '0;
    wait_held(1'b0, "full_release");
    // Drop while clr_ovf is held: the set must win on the push cycle.
    clr_ovf = 1'b1;
    wait_col(0, 1'b0, "prio_pre");
    pressed[0] = 1'b1;
    wait_col(0, 1'b1, "prio_col");
    tick(12);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_priority got=%b exp=1", overflow); end
    tick();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_after got=%b exp=0", overflow); end
    clr_ovf = 1'b0;
    pressed = '0;
    wait_held(1'b0, "prio_release");
    ready = 1'b1; tick(6); ready = 1'b0;
    checks++; if (popped.size() != 5) begin failures++; $display("FAIL full_order_n got=%0d exp=5", popped.size()); end
    for (int i = 0; i < 5 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] != order[i]) begin failures++; $display("FAIL full_order idx=%0d got=%0d exp=%0d", i, popped[i], order[i]); end
    end
  endtask

  task automatic test_reset_confirm();
    ready = 1'b0; popped.delete();
    wait_col(2, 1'b0, "rstc_pre");
    pressed[2*NC+2] = 1'b1;
    wait_col(2, 1'b1, "rstc_col");
    tick(6);
    checks++; if (col !== 4'b0100 || key_held !== 1'b0) begin failures++; $display("FAIL rstc_confirm col=%b held=%b exp=0100/0", col, key_held); end
    rst = 1'b1; pressed = '0;
    tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0 || valido !== 1'b0) begin failures++; $display("FAIL rstc_fifo got=%0d/%b exp=0/0", count, valido); end
    checks++; if (col !== 4'b0001 || key_held !== 1'b0) begin failures++; $display("FAIL rstc_state col=%b held=%b exp=0001/0", col, key_held); end
    tick(4);
    checks++; if (col !== 4'b0010) begin failures++; $display("FAIL rstc_scan got=%b exp=0010", col); end
    tick(30);
    checks++; if (count !== 3'd0 || popped.size() != 0) begin failures++; $display("FAIL rstc_no_push count=%0d pops=%0d exp=0/0", count, popped.size()); end
  endtask

  task automatic test_random();
    int exp_q[$];
    int r, c;
    popped.delete();
    rand_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(0, NR - 1);
      c = $urandom_range(0, NC - 1);
      exp_q.push_back(r * NC + c);
      press_key(r, c, $urandom_range(0, 12));
    end
    rand_ready = 1'b0;
    ready = 1'b1; tick(8); ready = 1'b0;
    checks++; if (popped.size() != exp_q.size()) begin failures++; $display("FAIL rand_n got=%0d exp=%0d", popped.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < popped.size(); i++) begin
      checks++;
      if (popped[i] != exp_q[i]) begin failures++; $display("FAIL rand_code idx=%0d got=%0d exp=%0d", i, popped[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL rand_end ovf=%b count=%0d exp=0/0", overflow, count); end
  endtask

  initial begin
    test_reset();
    test_hex_map();
    test_hold();
    test_latency();
    test_bounce();
    test_ghost();
    test_overflow();
    test_full_pop_push();
    test_reset_confirm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
